axi_lite_status: RTL and testbench

AXI4-Lite read-only slave that returns PL status words to the PS. It is the readback counterpart of the write-only control block. Reading word 0 captures a coherent snapshot of all status words, so multi-word counters stay consistent across reads. One word is a sticky event register that is cleared when read. Writes are accepted and refused with SLVERR so the master never hangs.

---
 rtl/axi_lite_pkg.sv | 31 +++
 rtl/axi_lite_status_sticky.sv | 28 ++
 rtl/axi_lite_status.sv | 191 +++++++++++++++++++
 tb/tb_axi_lite_status.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite status readback slave:
// response codes, FSM state encodings and address-to-index helpers.
package axi_lite_pkg;

  localparam int unsigned AXI_DW = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_e;

  typedef struct packed {
    logic [AXI_DW-1:0] data;
    logic [1:0]        resp;
  } rd_beat_t;

  // Byte address to 32-bit word index width.
  function automatic int unsigned idx_width(input int unsigned addr_w);
    return addr_w - 2;
  endfunction

endpackage

// File: rtl/axi_lite_status_sticky.sv
// Sticky event register: strobes accumulate until a read clears exactly
// the bits it returned; a strobe coincident with the clear is kept.
module axi_lite_status_sticky #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_en_i,
  input  logic [W-1:0] clr_mask_i,
  input  logic [W-1:0] event_pulse_i,
  output logic [W-1:0] sticky_o
);

  logic [W-1:0] sticky_q;
  logic [W-1:0] clr_c;

  assign clr_c    = clr_mask_i & {W{clr_en_i}};
  assign sticky_o = sticky_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= (sticky_q & ~clr_c) | event_pulse_i;
    end
  end

endmodule

// File: rtl/axi_lite_status.sv
// AXI4-Lite read-only status slave. Reading word 0 snapshots all other
// status words; EVT_REG is clear-on-read; writes are refused with SLVERR.
module axi_lite_status
  import axi_lite_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
  parameter int unsigned NUM_REGS           = 16,
  parameter int unsigned EVT_REG            = 15
) (
  input  logic                                     s_axi_aclk,
  input  logic                                     s_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            s_axi_araddr,
  input  logic [2:0]                               s_axi_arprot,
  input  logic                                     s_axi_arvalid,
  output logic                                     s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            s_axi_rdata,
  output logic [1:0]                               s_axi_rresp,
  output logic                                     s_axi_rvalid,
  input  logic                                     s_axi_rready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            s_axi_awaddr,
  input  logic [2:0]                               s_axi_awprot,
  input  logic                                     s_axi_awvalid,
  output logic                                     s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          s_axi_wstrb,
  input  logic                                     s_axi_wvalid,
  output logic                                     s_axi_wready,
  output logic [1:0]                               s_axi_bresp,
  output logic                                     s_axi_bvalid,
  input  logic                                     s_axi_bready,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   status_words,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            event_pulse
);

  localparam int unsigned DATA_W = C_S_AXI_DATA_WIDTH;
  localparam int unsigned IDX_W  = idx_width(C_S_AXI_ADDR_WIDTH);
  localparam int unsigned SNAP_W = (NUM_REGS - 1) * DATA_W;

  r_state_e          r_state_q;
  logic              arready_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;

  w_state_e          w_state_q;
  logic              awready_q;
  logic              wready_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;

  // Word k (k >= 1) lives at slice k-1; word 0 is always read live.
  logic [SNAP_W-1:0] snap_q;

  logic [IDX_W-1:0]  ar_idx_c;
  logic              ar_hs_c;
  logic              snap_ld_c;
  logic              evt_clr_c;
  logic [DATA_W-1:0] sticky_w;
  rd_beat_t          rd_beat_c;
  logic              unused_c;

  assign ar_idx_c  = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_hs_c   = s_axi_arvalid & arready_q;
  assign snap_ld_c = ar_hs_c && (ar_idx_c == '0);
  assign evt_clr_c = ar_hs_c && (ar_idx_c == IDX_W'(EVT_REG));

  assign unused_c = ^{s_axi_arprot, s_axi_araddr[1:0], s_axi_awaddr,
                      s_axi_awprot, s_axi_wdata, s_axi_wstrb};

  axi_lite_status_sticky #(
    .W (DATA_W)
  ) u_sticky (
    .clk_i         (s_axi_aclk),
    .rst_i         (s_axi_areset),
    .clr_en_i      (evt_clr_c),
    .clr_mask_i    (sticky_w),
    .event_pulse_i (event_pulse),
    .sticky_o      (sticky_w)
  );

  // Read decode for the index presented on the address channel.
  always_comb begin
    rd_beat_c.data = '0;
    rd_beat_c.resp = RESP_DECERR;
    if (32'(ar_idx_c) < NUM_REGS) begin
      rd_beat_c.resp = RESP_OKAY;
    end
    for (int unsigned k = 1; k < NUM_REGS; k++) begin
      if (ar_idx_c == IDX_W'(k)) begin
        rd_beat_c.data = snap_q[(k-1)*DATA_W +: DATA_W];
      end
    end
    if (ar_idx_c == '0) begin
      rd_beat_c.data = status_words[DATA_W-1:0];
    end
    if (ar_idx_c == IDX_W'(EVT_REG)) begin
      rd_beat_c.data = sticky_w;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      snap_q <= '0;
    end else if (snap_ld_c) begin
      snap_q <= status_words[NUM_REGS*DATA_W-1:DATA_W];
    end
  end

  // Read channel FSM.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs_c) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_beat_c.data;
            rresp_q   <= rd_beat_c.resp;
            r_state_q <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: begin
          r_state_q <= R_IDLE;
        end
      endcase
    end
  end

  // Write channel FSM: accept only when address and data arrive together.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (s_axi_awvalid && s_axi_wvalid && awready_q && wready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= RESP_SLVERR;
            w_state_q <= W_RESP;
          end else begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: begin
          w_state_q <= W_IDLE;
        end
      endcase
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_status.sv
// Scoreboard bench for axi_lite_status: drivers queue expected beats,
// a negedge monitor pops and compares on every R/B handshake.
module tb_axi_lite_status;

  logic         clk = 1'b0;
  logic         areset;
  logic [7:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [7:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [511:0] status_words;
  logic [31:0]  event_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  logic [33:0] rq[$];
  logic [1:0]  bq[$];

  always #5 clk = ~clk;

  axi_lite_status dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (areset),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (arprot),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (awprot),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .status_words  (status_words),
    .event_pulse   (event_pulse)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_word(input int k, input logic [31:0] v);
    status_words[k*32 +: 32] = v;
  endtask

  // Monitor: every R or B handshake is checked against the scoreboard.
  initial begin
    logic [33:0] er;
    logic [1:0]  eb;
    forever begin
      @(negedge clk);
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          chk("rd_unexpected_beat", {rdata, rresp}, 64'hx);
        end else begin
          er = rq.pop_front();
          chk("rd_beat_data_resp", {30'd0, rdata, rresp}, {30'd0, er});
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          chk("wr_unexpected_resp", 64'(bresp), 64'hx);
        end else begin
          eb = bq.pop_front();
          chk("wr_bresp", 64'(bresp), 64'(eb));
        end
      end
    end
  end

  task automatic rd(input logic [7:0] addr, input logic [31:0] edata,
                    input logic [1:0] eresp, input int rdly, input logic [31:0] hs_pulse);
    int t;
    @(posedge clk); #1;
    araddr  = addr;
    arvalid = 1'b1;
    rq.push_back({edata, eresp});
    t = 0;
    @(negedge clk);
    while (!arready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!arready) begin
      chk("rd_arready_timeout", 64'(arready), 64'd1);
      void'(rq.pop_back());
      arvalid = 1'b0;
      return;
    end
    chk("rd_rvalid_low_before_hs", 64'(rvalid), 64'd0);
    event_pulse = hs_pulse;
    @(posedge clk); #1;
    arvalid     = 1'b0;
    event_pulse = '0;
    rready      = (rdly == 0);
    @(negedge clk);
    chk("rd_rvalid_latency", 64'(rvalid), 64'd1);
    for (int i = 0; i < rdly; i++) begin
      chk("rd_stall_rvalid", 64'(rvalid), 64'd1);
      chk("rd_stall_arready", 64'(arready), 64'd0);
      chk("rd_stall_rdata", 64'(rdata), 64'(edata));
      @(posedge clk); #1;
      if (i == rdly - 1) rready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    chk("rd_post_arready", 64'(arready), 64'd1);
    chk("rd_post_rvalid", 64'(rvalid), 64'd0);
  endtask

  task automatic wr(input int bdly, input int lone);
    int t;
    @(posedge clk); #1;
    awaddr  = 8'h04;
    wdata   = 32'h0000_00FF;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    for (int i = 0; i < lone; i++) begin
      @(negedge clk);
      chk("wr_lone_aw_no_bvalid", 64'(bvalid), 64'd0);
    end
    if (lone > 0) begin
      @(posedge clk); #1;
    end
    wvalid = 1'b1;
    bq.push_back(2'b10);
    t = 0;
    @(negedge clk);
    while (!(awready && wready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!(awready && wready)) begin
      chk("wr_ready_timeout", 64'({awready, wready}), 64'd3);
      void'(bq.pop_back());
      awvalid = 1'b0;
      wvalid  = 1'b0;
      return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = (bdly == 0);
    @(negedge clk);
    chk("wr_bvalid_latency", 64'(bvalid), 64'd1);
    chk("wr_readies_low", 64'({awready, wready}), 64'd0);
    for (int i = 0; i < bdly; i++) begin
      chk("wr_stall_bvalid", 64'(bvalid), 64'd1);
      @(posedge clk); #1;
      if (i == bdly - 1) bready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk("wr_post_readies", 64'({awready, wready}), 64'd3);
    chk("wr_post_bvalid", 64'(bvalid), 64'd0);
  endtask

  initial begin
    areset       = 1'b1;
    araddr       = '0;
    arprot       = '0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awaddr       = '0;
    awprot       = '0;
    awvalid      = 1'b0;
    wdata        = '0;
    wstrb        = '0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    status_words = '0;
    event_pulse  = '0;
    set_word(0, 32'hA5A5_0000);
    set_word(1, 32'h0000_0001);
    set_word(3, 32'hDEAD_BEEF);
    set_word(15, 32'hFFFF_FFFF);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp}), 64'd0);
    @(posedge clk); #1;
    areset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_reset_arready", 64'(arready), 64'd1);
    chk("post_reset_aw_w_ready", 64'({awready, wready}), 64'd3);

    // Snapshot then read word 3.
    rd(8'h00, 32'hA5A5_0000, 2'b00, 0, '0);
    rd(8'h0C, 32'hDEAD_BEEF, 2'b00, 0, '0);

    // Snapshot coherency: word 1 only updates on a word 0 read.
    set_word(1, 32'h0000_0002);
    rd(8'h04, 32'h0000_0001, 2'b00, 0, '0);
    rd(8'h00, 32'hA5A5_0000, 2'b00, 0, '0);
    rd(8'h04, 32'h0000_0002, 2'b00, 0, '0);

    // Out of range index, then snapshot unchanged; low addr bits ignored.
    rd(8'h40, 32'h0000_0000, 2'b11, 0, '0);
    rd(8'h04, 32'h0000_0002, 2'b00, 0, '0);
    rd(8'h07, 32'h0000_0002, 2'b00, 0, '0);

    // Sticky: pulse bit 0, read while pulsing bit 5 in the handshake cycle.
    @(posedge clk); #1;
    event_pulse = 32'h0000_0001;
    @(posedge clk); #1;
    event_pulse = '0;
    rd(8'h3C, 32'h0000_0001, 2'b00, 0, 32'h0000_0020);
    rd(8'h3C, 32'h0000_0020, 2'b00, 0, '0);
    rd(8'h3C, 32'h0000_0000, 2'b00, 0, '0);

    // Read back-pressure for 10 cycles.
    rd(8'h0C, 32'hDEAD_BEEF, 2'b00, 10, '0);

    // Writes are refused; reads unaffected.
    wr(3, 0);
    rd(8'h04, 32'h0000_0002, 2'b00, 0, '0);
    wr(0, 3);

    // Concurrent read and write.
    fork
      rd(8'h04, 32'h0000_0002, 2'b00, 2, '0);
      wr(1, 0);
    join

    // Reset while both responses are pending abandons them.
    @(posedge clk); #1;
    event_pulse = 32'h0000_0008;
    araddr      = 8'h00;
    arvalid     = 1'b1;
    awvalid     = 1'b1;
    wvalid      = 1'b1;
    @(posedge clk); #1;
    event_pulse = '0;
    arvalid     = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    @(negedge clk);
    chk("mid_pre_reset_valids", 64'({rvalid, bvalid}), 64'd3);
    @(posedge clk); #1;
    areset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_reset_valids_drop", 64'({rvalid, bvalid, arready, awready}), 64'd0);
    @(posedge clk); #1;
    areset = 1'b0;
    rd(8'h3C, 32'h0000_0000, 2'b00, 0, '0);
    rd(8'h04, 32'h0000_0000, 2'b00, 0, '0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rd_queue_drained", 64'(rq.size()), 64'd0);
    chk("wr_queue_drained", 64'(bq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
